// File: rtl/imuldiv_div_front_if.sv
`default_nettype none
// ============================================================================
//  Module      : imuldiv_div_front_if
//  Description : Handshake bundle around the divide front-end. It carries the
//                execute-stage request, the divider request/response pair and
//                the consumer response.
//                master = front-end view, slave = surrounding environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface imuldiv_div_front_if;
    // Execute-stage request
    logic        req_val;
    logic        req_rdy;
    logic [1:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;
    // Request to the iterative divider
    logic        divreq_val;
    logic        divreq_rdy;
    logic        divreq_msg_fn;
    logic [31:0] divreq_msg_a;
    logic [31:0] divreq_msg_b;
    // Response from the divider: {remainder, quotient}
    logic        divresp_val;
    logic        divresp_rdy;
    logic [63:0] divresp_msg_result;
    // Selected 32-bit result toward the consumer
    logic        resp_val;
    logic        resp_rdy;
    logic [31:0] resp_data;

    modport master (
        input  req_val, req_op, req_a, req_b,
        output req_rdy,
        output divreq_val, divreq_msg_fn, divreq_msg_a, divreq_msg_b,
        input  divreq_rdy,
        input  divresp_val, divresp_msg_result,
        output divresp_rdy,
        output resp_val, resp_data,
        input  resp_rdy
    );

    modport slave (
        output req_val, req_op, req_a, req_b,
        input  req_rdy,
        input  divreq_val, divreq_msg_fn, divreq_msg_a, divreq_msg_b,
        output divreq_rdy,
        output divresp_val, divresp_msg_result,
        input  divresp_rdy,
        input  resp_val, resp_data,
        output resp_rdy
    );
endinterface
`default_nettype wire

// File: rtl/imuldiv_div_front.sv
`default_nettype none
// ============================================================================
//  Module      : imuldiv_div_front
//  Description : Front-end of the iterative divider. It forwards operands
//                combinationally and remembers, for each in-flight operation,
//                whether the quotient or the remainder is wanted. It then
//                returns the selected half of each divider result through a
//                small output queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module imuldiv_div_front #(
    parameter int TAG_DEPTH = 2,
    parameter int OUT_DEPTH = 2
) (
    input  wire logic           clk,
    input  wire logic           reset,   // synchronous, active-low
    imuldiv_div_front_if.master bus
);

    localparam int TAG_AW = $clog2(TAG_DEPTH);
    localparam int TAG_CW = $clog2(TAG_DEPTH + 1);
    localparam int OUT_AW = $clog2(OUT_DEPTH);
    localparam int OUT_CW = $clog2(OUT_DEPTH + 1);

    localparam logic [TAG_CW-1:0] c_TAG_FULL_CNT = TAG_CW'(TAG_DEPTH);
    localparam logic [OUT_CW-1:0] c_OUT_FULL_CNT = OUT_CW'(OUT_DEPTH);

    // Tag FIFO: one bit per in-flight op, 1 = remainder wanted
    logic              tag_mem_q [TAG_DEPTH];
    logic [TAG_AW-1:0] tag_wr_ptr_q, tag_wr_ptr_d;
    logic [TAG_AW-1:0] tag_rd_ptr_q, tag_rd_ptr_d;
    logic [TAG_CW-1:0] tag_cnt_q,    tag_cnt_d;

    // Output queue of selected 32-bit results
    logic [31:0]       out_mem_q [OUT_DEPTH];
    logic [OUT_AW-1:0] out_wr_ptr_q, out_wr_ptr_d;
    logic [OUT_AW-1:0] out_rd_ptr_q, out_rd_ptr_d;
    logic [OUT_CW-1:0] out_cnt_q,    out_cnt_d;

    logic        w_tag_full;
    logic        w_tag_empty;
    logic        w_out_full;
    logic        w_out_empty;
    logic        w_req_rdy;
    logic        w_divresp_rdy;
    logic        w_resp_val;
    logic        w_req_fire;
    logic        w_divresp_fire;
    logic        w_resp_fire;
    logic [31:0] w_sel_data;

    assign w_tag_full  = (tag_cnt_q == c_TAG_FULL_CNT);
    assign w_tag_empty = (tag_cnt_q == '0);
    assign w_out_full  = (out_cnt_q == c_OUT_FULL_CNT);
    assign w_out_empty = (out_cnt_q == '0);

    // Handshakes are gated by reset so nothing is offered while it is held low,
    // even before the first clock edge has cleared the counters.
    assign w_req_rdy     = reset & bus.divreq_rdy & ~w_tag_full;
    assign w_divresp_rdy = reset & ~w_tag_empty & ~w_out_full;
    assign w_resp_val    = reset & ~w_out_empty;

    assign w_req_fire     = bus.req_val & w_req_rdy;
    assign w_divresp_fire = bus.divresp_val & w_divresp_rdy;
    assign w_resp_fire    = w_resp_val & bus.resp_rdy;

    // The oldest tag picks which half of the in-order divider result is kept
    assign w_sel_data = tag_mem_q[tag_rd_ptr_q] ? bus.divresp_msg_result[63:32]
                                                : bus.divresp_msg_result[31:0];

    assign bus.req_rdy       = w_req_rdy;
    assign bus.divreq_val    = reset & bus.req_val & ~w_tag_full;
    assign bus.divreq_msg_fn = bus.req_op[0];
    assign bus.divreq_msg_a  = bus.req_a;
    assign bus.divreq_msg_b  = bus.req_b;
    assign bus.divresp_rdy   = w_divresp_rdy;
    assign bus.resp_val      = w_resp_val;
    assign bus.resp_data     = out_mem_q[out_rd_ptr_q];

    // Next-state of tag FIFO pointers and occupancy
    always_comb begin
        tag_wr_ptr_d = tag_wr_ptr_q;
        tag_rd_ptr_d = tag_rd_ptr_q;
        tag_cnt_d    = tag_cnt_q;
        if (w_req_fire) begin
            tag_wr_ptr_d = tag_wr_ptr_q + TAG_AW'(1);
        end
        if (w_divresp_fire) begin
            tag_rd_ptr_d = tag_rd_ptr_q + TAG_AW'(1);
        end
        case ({w_req_fire, w_divresp_fire})
            2'b10:   tag_cnt_d = tag_cnt_q + TAG_CW'(1);
            2'b01:   tag_cnt_d = tag_cnt_q - TAG_CW'(1);
            default: tag_cnt_d = tag_cnt_q;
        endcase
    end

    // Next-state of output queue pointers and occupancy
    always_comb begin
        out_wr_ptr_d = out_wr_ptr_q;
        out_rd_ptr_d = out_rd_ptr_q;
        out_cnt_d    = out_cnt_q;
        if (w_divresp_fire) begin
            out_wr_ptr_d = out_wr_ptr_q + OUT_AW'(1);
        end
        if (w_resp_fire) begin
            out_rd_ptr_d = out_rd_ptr_q + OUT_AW'(1);
        end
        case ({w_divresp_fire, w_resp_fire})
            2'b10:   out_cnt_d = out_cnt_q + OUT_CW'(1);
            2'b01:   out_cnt_d = out_cnt_q - OUT_CW'(1);
            default: out_cnt_d = out_cnt_q;
        endcase
    end

    // Pointer and counter registers, cleared while reset is low
    always_ff @(posedge clk) begin
        if (!reset) begin
            tag_wr_ptr_q <= '0;
            tag_rd_ptr_q <= '0;
            tag_cnt_q    <= '0;
            out_wr_ptr_q <= '0;
            out_rd_ptr_q <= '0;
            out_cnt_q    <= '0;
        end else begin
            tag_wr_ptr_q <= tag_wr_ptr_d;
            tag_rd_ptr_q <= tag_rd_ptr_d;
            tag_cnt_q    <= tag_cnt_d;
            out_wr_ptr_q <= out_wr_ptr_d;
            out_rd_ptr_q <= out_rd_ptr_d;
            out_cnt_q    <= out_cnt_d;
        end
    end

    // Storage arrays; contents only matter once the counters say so
    always_ff @(posedge clk) begin
        if (w_req_fire) begin
            tag_mem_q[tag_wr_ptr_q] <= bus.req_op[1];
        end
        if (w_divresp_fire) begin
            out_mem_q[out_wr_ptr_q] <= w_sel_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imuldiv_div_front.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imuldiv_div_front
//  Description : Self-checking bench for imuldiv_div_front: directed
//                scenarios plus a randomized run against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imuldiv_div_front;

    localparam int TAG_DEPTH = 2;
    localparam int OUT_DEPTH = 2;

    logic clk = 1'b0;
    logic reset;
    int   n_pass  = 0;
    int   n_total = 0;

    imuldiv_div_front_if bus ();

    imuldiv_div_front #(
        .TAG_DEPTH (TAG_DEPTH),
        .OUT_DEPTH (OUT_DEPTH)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference divider: truncating signed or unsigned divide, {rem, quot}
    function automatic logic [63:0] ref_div(input logic fn, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] q;
        logic [31:0] r;
        if (fn) begin
            q = a / b;
            r = a % b;
        end else begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end
        return {r, q};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.req_val            = 1'b0;
        bus.req_op             = 2'b00;
        bus.req_a              = 32'd0;
        bus.req_b              = 32'd0;
        bus.divreq_rdy         = 1'b1;
        bus.divresp_val        = 1'b0;
        bus.divresp_msg_result = 64'd0;
        bus.resp_rdy           = 1'b1;
    endtask

    task automatic test_reset();
        reset           = 1'b0;
        bus.req_val     = 1'b1;
        bus.divresp_val = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_total++;
            if ({bus.req_rdy, bus.divreq_val, bus.divresp_rdy, bus.resp_val} !== 4'b0000)
                $display("FAIL reset_hold cyc%0d: got rdy/val/drdy/rval=%b expected 0000", i,
                         {bus.req_rdy, bus.divreq_val, bus.divresp_rdy, bus.resp_val});
            else n_pass++;
            tick();
        end
        reset           = 1'b1;
        bus.req_val     = 1'b0;
        bus.divresp_val = 1'b0;
        #1;
        n_total++;
        if ({bus.req_rdy, bus.divresp_rdy, bus.resp_val} !== 3'b100)
            $display("FAIL reset_release: got req_rdy/divresp_rdy/resp_val=%b expected 100",
                     {bus.req_rdy, bus.divresp_rdy, bus.resp_val});
        else n_pass++;
        tick();
        n_total++;
        if (bus.resp_val !== 1'b0)
            $display("FAIL reset_spurious: got resp_val=%b expected 0", bus.resp_val);
        else n_pass++;
    endtask

    task automatic test_single_ops();
        logic [1:0]  ops  [3];
        logic [31:0] as   [3];
        logic [63:0] res  [3];
        logic        efn  [3];
        logic [31:0] edat [3];
        ops[0] = 2'b00; as[0] = 32'hFFFF_FFF9; res[0] = 64'hFFFF_FFFF_FFFF_FFFD;
        efn[0] = 1'b0;  edat[0] = 32'hFFFF_FFFD;
        ops[1] = 2'b10; as[1] = 32'hFFFF_FFF9; res[1] = 64'hFFFF_FFFF_FFFF_FFFD;
        efn[1] = 1'b0;  edat[1] = 32'hFFFF_FFFF;
        ops[2] = 2'b11; as[2] = 32'd7;         res[2] = {32'd1, 32'd3};
        efn[2] = 1'b1;  edat[2] = 32'h0000_0001;
        for (int i = 0; i < 3; i++) begin
            bus.req_val = 1'b1;
            bus.req_op  = ops[i];
            bus.req_a   = as[i];
            bus.req_b   = 32'd2;
            #1;
            n_total++;
            if ({bus.divreq_val, bus.req_rdy} !== 2'b11)
                $display("FAIL op%0d_fwd_handshake: got divreq_val/req_rdy=%b expected 11", i,
                         {bus.divreq_val, bus.req_rdy});
            else n_pass++;
            n_total++;
            if (bus.divreq_msg_fn !== efn[i])
                $display("FAIL op%0d_fn: got %b expected %b", i, bus.divreq_msg_fn, efn[i]);
            else n_pass++;
            n_total++;
            if ({bus.divreq_msg_a, bus.divreq_msg_b} !== {as[i], 32'd2})
                $display("FAIL op%0d_operands: got a=%h b=%h expected a=%h b=%h", i,
                         bus.divreq_msg_a, bus.divreq_msg_b, as[i], 32'd2);
            else n_pass++;
            tick();
            bus.req_val            = 1'b0;
            bus.divresp_val        = 1'b1;
            bus.divresp_msg_result = res[i];
            #1;
            n_total++;
            if (bus.divresp_rdy !== 1'b1)
                $display("FAIL op%0d_divresp_rdy: got %b expected 1", i, bus.divresp_rdy);
            else n_pass++;
            tick();
            bus.divresp_val = 1'b0;
            #1;
            n_total++;
            if (bus.resp_val !== 1'b1 || bus.resp_data !== edat[i])
                $display("FAIL op%0d_result: got val=%b data=%h expected val=1 data=%h", i,
                         bus.resp_val, bus.resp_data, edat[i]);
            else n_pass++;
            tick();
            n_total++;
            if (bus.resp_val !== 1'b0)
                $display("FAIL op%0d_drained: got resp_val=%b expected 0", i, bus.resp_val);
            else n_pass++;
        end
    endtask

    task automatic test_tag_full();
        drive_idle();
        bus.req_val = 1'b1;
        bus.req_a   = 32'd100;
        bus.req_b   = 32'd10;
        #1;
        n_total++;
        if (bus.req_rdy !== 1'b1) $display("FAIL tagfull_req1: got req_rdy=%b expected 1", bus.req_rdy);
        else n_pass++;
        tick();
        bus.req_a = 32'd200;
        #1;
        n_total++;
        if (bus.req_rdy !== 1'b1) $display("FAIL tagfull_req2: got req_rdy=%b expected 1", bus.req_rdy);
        else n_pass++;
        tick();
        bus.req_a = 32'd300;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_total++;
            if ({bus.req_rdy, bus.divreq_val} !== 2'b00)
                $display("FAIL tagfull_block cyc%0d: got req_rdy/divreq_val=%b expected 00", i,
                         {bus.req_rdy, bus.divreq_val});
            else n_pass++;
            tick();
        end
        bus.divresp_val        = 1'b1;
        bus.divresp_msg_result = {32'd0, 32'd10};
        #1;
        n_total++;
        if (bus.divresp_rdy !== 1'b1)
            $display("FAIL tagfull_divresp_rdy: got %b expected 1", bus.divresp_rdy);
        else n_pass++;
        tick();
        bus.divresp_val = 1'b0;
        #1;
        n_total++;
        if (bus.req_rdy !== 1'b1) $display("FAIL tagfull_freed: got req_rdy=%b expected 1", bus.req_rdy);
        else n_pass++;
        n_total++;
        if (bus.resp_val !== 1'b1 || bus.resp_data !== 32'd10)
            $display("FAIL tagfull_res1: got val=%b data=%h expected val=1 data=%h",
                     bus.resp_val, bus.resp_data, 32'd10);
        else n_pass++;
        tick();
        bus.req_val            = 1'b0;
        bus.divresp_val        = 1'b1;
        bus.divresp_msg_result = {32'd0, 32'd20};
        tick();
        bus.divresp_msg_result = {32'd0, 32'd30};
        #1;
        n_total++;
        if (bus.resp_val !== 1'b1 || bus.resp_data !== 32'd20)
            $display("FAIL tagfull_res2: got val=%b data=%h expected val=1 data=%h",
                     bus.resp_val, bus.resp_data, 32'd20);
        else n_pass++;
        tick();
        bus.divresp_val = 1'b0;
        #1;
        n_total++;
        if (bus.resp_val !== 1'b1 || bus.resp_data !== 32'd30)
            $display("FAIL tagfull_res3: got val=%b data=%h expected val=1 data=%h",
                     bus.resp_val, bus.resp_data, 32'd30);
        else n_pass++;
        tick();
        n_total++;
        if ({bus.resp_val, bus.divresp_rdy} !== 2'b00)
            $display("FAIL tagfull_empty: got resp_val/divresp_rdy=%b expected 00",
                     {bus.resp_val, bus.divresp_rdy});
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp_out [3];
        exp_out[0] = 32'd3; exp_out[1] = 32'd1; exp_out[2] = 32'd3;
        drive_idle();
        bus.resp_rdy = 1'b0;
        bus.req_val  = 1'b1;
        bus.req_op   = 2'b00; bus.req_a = 32'd10; bus.req_b = 32'd3;
        tick();
        bus.req_op   = 2'b10;
        tick();
        bus.req_op   = 2'b01; bus.req_a = 32'd9;
        bus.divresp_val        = 1'b1;
        bus.divresp_msg_result = {32'd1, 32'd3};
        #1;
        n_total++;
        if ({bus.divresp_rdy, bus.req_rdy} !== 2'b10)
            $display("FAIL bp_fire1: got divresp_rdy/req_rdy=%b expected 10",
                     {bus.divresp_rdy, bus.req_rdy});
        else n_pass++;
        tick();
        #1;
        n_total++;
        if ({bus.divresp_rdy, bus.req_rdy} !== 2'b11)
            $display("FAIL bp_fire2: got divresp_rdy/req_rdy=%b expected 11",
                     {bus.divresp_rdy, bus.req_rdy});
        else n_pass++;
        tick();
        bus.req_val            = 1'b0;
        bus.divresp_msg_result = {32'd0, 32'd3};
        for (int i = 0; i < 2; i++) begin
            #1;
            n_total++;
            if (bus.divresp_rdy !== 1'b0)
                $display("FAIL bp_stall cyc%0d: got divresp_rdy=%b expected 0", i, bus.divresp_rdy);
            else n_pass++;
            if (i == 0) tick();
        end
        bus.resp_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) bus.divresp_val = 1'b0;
            #1;
            n_total++;
            if (bus.resp_val !== 1'b1 || bus.resp_data !== exp_out[i])
                $display("FAIL bp_out%0d: got val=%b data=%h expected val=1 data=%h", i,
                         bus.resp_val, bus.resp_data, exp_out[i]);
            else n_pass++;
            tick();
        end
        #1;
        n_total++;
        if (bus.resp_val !== 1'b0) $display("FAIL bp_drained: got resp_val=%b expected 0", bus.resp_val);
        else n_pass++;
    endtask

    task automatic test_reset_midop();
        drive_idle();
        bus.resp_rdy = 1'b0;
        bus.req_val  = 1'b1;
        bus.req_a    = 32'd8; bus.req_b = 32'd2;
        tick();
        tick();
        bus.req_val            = 1'b0;
        bus.divresp_val        = 1'b1;
        bus.divresp_msg_result = {32'd0, 32'd4};
        tick();
        bus.divresp_val = 1'b0;
        bus.req_val     = 1'b1;
        tick();
        bus.req_val = 1'b0;
        reset       = 1'b0;
        #1;
        n_total++;
        if ({bus.req_rdy, bus.divreq_val, bus.divresp_rdy, bus.resp_val} !== 4'b0000)
            $display("FAIL midrst_hold: got %b expected 0000",
                     {bus.req_rdy, bus.divreq_val, bus.divresp_rdy, bus.resp_val});
        else n_pass++;
        tick();
        reset           = 1'b1;
        bus.divresp_val = 1'b1;
        #1;
        n_total++;
        if ({bus.resp_val, bus.divresp_rdy, bus.req_rdy} !== 3'b001)
            $display("FAIL midrst_after: got resp_val/divresp_rdy/req_rdy=%b expected 001",
                     {bus.resp_val, bus.divresp_rdy, bus.req_rdy});
        else n_pass++;
        tick();
        bus.divresp_val = 1'b0;
        #1;
        n_total++;
        if ({bus.resp_val, bus.divresp_rdy} !== 2'b00)
            $display("FAIL midrst_stray: got resp_val/divresp_rdy=%b expected 00",
                     {bus.resp_val, bus.divresp_rdy});
        else n_pass++;
        bus.resp_rdy = 1'b1;
        bus.req_val  = 1'b1;
        tick();
        bus.req_val            = 1'b0;
        bus.divresp_val        = 1'b1;
        bus.divresp_msg_result = ref_div(1'b0, 32'd8, 32'd2);
        tick();
        bus.divresp_val = 1'b0;
        #1;
        n_total++;
        if (bus.resp_val !== 1'b1 || bus.resp_data !== 32'd4)
            $display("FAIL midrst_div8_2: got val=%b data=%h expected val=1 data=%h",
                     bus.resp_val, bus.resp_data, 32'd4);
        else n_pass++;
        tick();
    endtask

    task automatic test_random();
        logic        tagq [$];
        logic [63:0] divq [$];
        logic [31:0] outq [$];
        logic        e_req_rdy, e_divreq_val, e_divresp_rdy, e_resp_val;
        logic        rf, df, of;
        for (int cyc = 0; cyc < 400; cyc++) begin
            bus.req_val  = $urandom_range(0, 1);
            bus.req_op   = 2'($urandom_range(0, 3));
            bus.req_a    = $urandom;
            bus.req_b    = $urandom_range(2, 50);
            if ($urandom_range(0, 1) == 1) bus.req_b = -bus.req_b;
            bus.divreq_rdy  = ($urandom_range(0, 3) != 0);
            bus.resp_rdy    = ($urandom_range(0, 2) != 0);
            bus.divresp_val = (divq.size() > 0) && ($urandom_range(0, 1) == 1);
            bus.divresp_msg_result = (divq.size() > 0) ? divq[0] : {$urandom, $urandom};
            #1;
            e_req_rdy     = bus.divreq_rdy && (tagq.size() < TAG_DEPTH);
            e_divreq_val  = bus.req_val && (tagq.size() < TAG_DEPTH);
            e_divresp_rdy = (tagq.size() > 0) && (outq.size() < OUT_DEPTH);
            e_resp_val    = (outq.size() > 0);
            n_total++;
            if ({bus.req_rdy, bus.divreq_val, bus.divresp_rdy, bus.resp_val} !==
                {e_req_rdy, e_divreq_val, e_divresp_rdy, e_resp_val})
                $display("FAIL rand_hs cyc%0d: got rdy/val/drdy/rval=%b expected %b", cyc,
                         {bus.req_rdy, bus.divreq_val, bus.divresp_rdy, bus.resp_val},
                         {e_req_rdy, e_divreq_val, e_divresp_rdy, e_resp_val});
            else n_pass++;
            if (e_resp_val) begin
                n_total++;
                if (bus.resp_data !== outq[0])
                    $display("FAIL rand_data cyc%0d: got %h expected %h", cyc, bus.resp_data, outq[0]);
                else n_pass++;
            end
            if (e_divreq_val) begin
                n_total++;
                if ({bus.divreq_msg_fn, bus.divreq_msg_a, bus.divreq_msg_b} !==
                    {bus.req_op[0], bus.req_a, bus.req_b})
                    $display("FAIL rand_fwd cyc%0d: got fn=%b a=%h b=%h expected fn=%b a=%h b=%h",
                             cyc, bus.divreq_msg_fn, bus.divreq_msg_a, bus.divreq_msg_b,
                             bus.req_op[0], bus.req_a, bus.req_b);
                else n_pass++;
            end
            rf = bus.req_val && e_req_rdy;
            df = bus.divresp_val && e_divresp_rdy;
            of = e_resp_val && bus.resp_rdy;
            if (of) void'(outq.pop_front());
            if (df) begin
                outq.push_back(tagq[0] ? divq[0][63:32] : divq[0][31:0]);
                void'(tagq.pop_front());
                void'(divq.pop_front());
            end
            if (rf) begin
                tagq.push_back(bus.req_op[1]);
                divq.push_back(ref_div(bus.req_op[0], bus.req_a, bus.req_b));
            end
            tick();
        end
    endtask

    initial begin
        drive_idle();
        reset = 1'b0;
        test_reset();
        test_single_ops();
        test_tag_full();
        test_back_to_back();
        test_reset_midop();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
